// File: rtl/fifo.sv
// -----------------------------------------------------------------------------
// fifo: synchronous single-clock FIFO with first-word-fall-through read data.
//
// Buffers byte streams between the UART RX/TX cores and the bus-facing UART
// controller. One instance sits on each direction of the data path.
//
// Parameters:
//   WIDTH  data word width in bits (default 8)
//   DEPTH  number of entries; a power of two, >= 2 (default 16)
//
// Ports:
//   clk    in   clock; all state updates on the rising edge
//   rstn   in   asynchronous active-low reset
//   din    in   write data, sampled on the edge where w=1
//   w      in   write strobe, one word per asserted edge
//   r      in   read strobe, pops the current head
//   dout   out  head-of-queue data, combinational (FWFT); 0 when empty
//   full   out  1 when count == DEPTH
//   empty  out  1 when count == 0
//   count  out  number of stored words, 0..DEPTH
// -----------------------------------------------------------------------------
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [WIDTH-1:0]         din,
    input  logic                     w,
    input  logic                     r,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic wr_en;
    logic rd_en;

    // Status comes straight from the count register, so full and empty move
    // on the same edge as count and the wrap of equal pointers is never
    // ambiguous.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // A read on a full queue frees the head slot on the same edge, so the
    // simultaneous write is allowed to land in it.
    assign rd_en = r && !empty;
    assign wr_en = w && (!full || rd_en);

    // FWFT: the head is presented without waiting for the read strobe.
    assign dout = empty ? '0 : mem[rptr_q];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;

        if (wr_en) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rptr_d = rptr_q + PTR_W'(1);
        end

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its neighbours.
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array has no reset; empty gates dout, so stale
    // contents are never observable and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q] <= din;
        end
    end

endmodule

// File: tb/tb_fifo.sv
// -----------------------------------------------------------------------------
// tb_fifo: self-checking bench for fifo (WIDTH=8, DEPTH=16).
// A table of single-cycle vectors with hand-computed post-edge state is
// applied in a loop; a queue scoreboard tracks expected contents and checks
// every popped word. Hand-written sequences cover fill/overflow/drain,
// full-queue simultaneous access, wrap-around and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clk;
    logic             rstn;
    logic [WIDTH-1:0] din;
    logic             w;
    logic             r;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic [4:0]       count;

    int vectors;
    int miscompares;

    logic [WIDTH-1:0] sb [$];

    typedef struct {
        logic       w;
        logic       r;
        logic [7:0] din;
        logic [7:0] exp_dout;
        logic [4:0] exp_count;
        logic       exp_empty;
        logic       exp_full;
    } vec_t;

    vec_t tbl [15];

    fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .din   (din),
        .w     (w),
        .r     (r),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus. The head is checked against the scoreboard before
    // the popping edge; state is checked against the scoreboard after it.
    task automatic step(input logic wi, input logic ri, input logic [7:0] di,
                        output logic [7:0] rd);
        logic acc_r;
        logic acc_w;
        logic [7:0] exp_head;
        @(negedge clk);
        w   = wi;
        r   = ri;
        din = di;
        #1;
        rd    = dout;
        acc_r = ri && (sb.size() > 0);
        acc_w = wi && ((sb.size() < DEPTH) || acc_r);
        if (acc_r) begin
            exp_head = sb.pop_front();
            check("pop_data", dout, exp_head);
        end
        @(posedge clk);
        if (acc_w) sb.push_back(di);
        #1;
        check("sb_count", count, sb.size());
        check("sb_empty", empty, sb.size() == 0);
        check("sb_full", full, sb.size() == DEPTH);
        check("sb_dout", dout, (sb.size() > 0) ? sb[0] : 8'h00);
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] last;
        vectors     = 0;
        miscompares = 0;
        w    = 1'b0;
        r    = 1'b0;
        din  = '0;
        rstn = 1'b1;

        // Asynchronous reset mid-cycle, checked before any clock edge.
        #2 rstn = 1'b0;
        #1;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_dout", dout, 0);
        @(negedge clk);
        rstn = 1'b1;

        //        w  r  din    dout   cnt emp full
        tbl[0]  = '{1, 0, 8'h55, 8'h55, 1, 0, 0};
        tbl[1]  = '{1, 0, 8'hA3, 8'h55, 2, 0, 0};
        tbl[2]  = '{1, 0, 8'h0F, 8'h55, 3, 0, 0};
        tbl[3]  = '{0, 1, 8'h00, 8'hA3, 2, 0, 0};
        tbl[4]  = '{0, 1, 8'h00, 8'h0F, 1, 0, 0};
        tbl[5]  = '{0, 1, 8'h00, 8'h00, 0, 1, 0};
        tbl[6]  = '{0, 1, 8'h00, 8'h00, 0, 1, 0};  // underflow
        tbl[7]  = '{0, 1, 8'h00, 8'h00, 0, 1, 0};  // underflow
        tbl[8]  = '{0, 1, 8'h00, 8'h00, 0, 1, 0};  // underflow
        tbl[9]  = '{1, 0, 8'h42, 8'h42, 1, 0, 0};
        tbl[10] = '{0, 1, 8'h00, 8'h00, 0, 1, 0};
        tbl[11] = '{1, 0, 8'h11, 8'h11, 1, 0, 0};
        tbl[12] = '{1, 1, 8'h22, 8'h22, 1, 0, 0};  // r/w with one entry
        tbl[13] = '{0, 1, 8'h00, 8'h00, 0, 1, 0};
        tbl[14] = '{1, 1, 8'h33, 8'h33, 1, 0, 0};  // r/w while empty

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].w, tbl[i].r, tbl[i].din, rd);
            check($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dout);
            check($sformatf("tbl%0d_count", i), count, tbl[i].exp_count);
            check($sformatf("tbl%0d_empty", i), empty, tbl[i].exp_empty);
            check($sformatf("tbl%0d_full", i), full, tbl[i].exp_full);
        end
        step(0, 1, 8'h00, rd);
        check("drain_33", rd, 8'h33);

        // Fill with 0..15, overflow write dropped, drain in order.
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(i), rd);
        check("fill_full", full, 1);
        check("fill_count", count, 16);
        step(1, 0, 8'hFF, rd);
        check("ovf_count", count, 16);
        check("ovf_head", dout, 8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 8'h00, rd);
            check($sformatf("drain%0d", i), rd, 8'(i));
        end
        check("drain_empty", empty, 1);

        // Full queue, head 0x00: simultaneous r/w keeps count at DEPTH.
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(i), rd);
        step(1, 1, 8'h99, rd);
        check("fullrw_popped", rd, 8'h00);
        check("fullrw_count", count, 16);
        check("fullrw_full", full, 1);
        last = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 8'h00, rd);
            last = rd;
        end
        check("fullrw_last", last, 8'h99);
        check("fullrw_empty", empty, 1);

        // Wrap-around: 40 write/read pairs.
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 8'(8'h80 + i), rd);
            step(0, 1, 8'h00, rd);
            check($sformatf("wrap%0d", i), rd, 8'(8'h80 + i));
        end

        // Reset mid-operation discards queued data immediately.
        step(1, 0, 8'hC1, rd);
        step(1, 0, 8'hC2, rd);
        @(negedge clk);
        w = 1'b0;
        r = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("mrst_count", count, 0);
        check("mrst_empty", empty, 1);
        check("mrst_dout", dout, 0);
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        step(1, 0, 8'h5A, rd);
        check("post_rst_dout", dout, 8'h5A);

        @(negedge clk);
        w = 1'b0;
        r = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Synchronous single-clock FIFO queue with first-word-fall-through (FWFT) read data.
- Buffers byte streams between the UART receiver/transmitter cores and the bus-facing UART controller.
- One instance sits on the RX path (receiver writes, bus reads).
- One instance sits on the TX path (bus writes, transmitter reads).
- Exposes full/empty status plus an occupancy count.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of entries; must be a power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- din  input  WIDTH  write data, sampled on the clk edge where w=1.
- w  input  1  write strobe, single-cycle per word, level-sampled each edge.
- r  input  1  read strobe, single-cycle per word; pops the current head.
- dout  output  WIDTH  head-of-queue data, combinational (FWFT).
- full  output  1  1 when count==DEPTH.
- empty  output  1  1 when count==0.
- count  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.

Behaviour:
- Reset (rstn=0, asynchronous assert, synchronous-safe deassert):
  - write pointer, read pointer and count go to 0.
  - empty=1, full=0, count=0, dout=0.
  - Storage array is not reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- full and empty are derived from the count register; no pointer-equality ambiguity.
- Write: on an edge with w=1 and full=0:
  - mem[wptr] <= din; wptr increments.
- Read: on an edge with r=1 and empty=0, rptr increments.
- FWFT dout:
  - When empty=0, dout = mem[rptr] combinationally.
  - dout is valid in the same cycle r is asserted, so the consumer captures dout on the same edge that pops it (zero-latency read).
  - When empty=1, dout = 0.
- Write-to-read latency: a word written at edge N is visible on dout, with empty=0, after edge N (usable from cycle N+1).
- Overflow: w=1 while full=1 and r=0 → write dropped; no state change; stored data is not corrupted.
- Underflow: r=1 while empty=1 and w=0 → ignored; pointers and count are unchanged.
- Simultaneous w=1 and r=1:
  - Not empty and not full: both occur; count unchanged.
  - full=1: read pops the head and the write is accepted into the freed slot; count stays DEPTH.
  - empty=1: write accepted, read ignored; count becomes 1.
- count update: +1 on an accepted write only, -1 on an accepted read only, unchanged otherwise.
- full and empty are registered-consistent with count; they update on the same edge as count.
- Reset mid-operation immediately empties the queue; contents are discarded logically.
- There are no other outputs and no error flags; overflow and underflow are silent.

Test Plan:
- Reset with rstn=0 asynchronously mid-cycle → empty=1, full=0, count=0, dout=0 immediately, without waiting for a clock edge.
- Write 0x55, 0xA3, 0x0F with one strobe each:
  - After the first write, dout=0x55, empty=0, count=1.
  - Pulse r three times → dout sequence 0x55, 0xA3, 0x0F; then empty=1, dout=0.
- Fill DEPTH=16 with values 0..15 → full=1, count=16.
  - Extra write of 0xFF is dropped.
  - Drain all 16 → reads 0..15 in order, 0xFF never appears.
- Underflow: r pulsed 3 times while empty → count=0 and pointers unchanged.
  - A subsequent write of 0x42 appears on dout.
- Simultaneous r/w:
  - Queue holding 0x11, then r=w=1 with din=0x22 → count stays 1, dout=0x22.
  - When full with head 0x00, r=w=1 with din=0x99 → count=16, and 0x99 is read last after the wrap.
- Wrap-around: 40 interleaved write/read pairs with incrementing data across pointer wrap → every read matches its write order, and the empty/full flags stay correct.
